mux_4_to_1_arbiter: RTL and testbench
=====================================

# mux_4_to_1_arbiter

Registered 4-to-1 multiplexer with round-robin arbitration and valid/ready handshakes. It merges four input lanes onto one output stream and tags each beat with its source lane on `out_sel`. That tag is the 2-bit select a downstream 1-to-4 demultiplexer uses to route the beat back out. Optional burst locking keeps a lane granted for up to `BURST` consecutive beats.

## Interface
- `WIDTH`, 8: data width per lane; legal range ≥1.
- `BURST`, 1: maximum consecutive beats granted to one lane before re-arbitration; legal range 1..16.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on rising edge of `clk`.
- `in_data` input 4*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input 4: lane i has a beat available.
- `in_ready` output 4: lane i's beat is accepted this cycle. One-hot or zero.
- `out_data` output WIDTH: registered data.
- `out_sel` output 2: registered source lane of `out_data`.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: downstream accepts the beat.

## Operation
- Transfer on input lane i occurs when `in_valid[i] & in_ready[i]`. Transfer on output occurs when `out_valid & out_ready`.
- `load = !out_valid | out_ready`. The output register can take a new beat only when `load` is high.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and internal state.
  - `in_ready[i]` = `load & grant[i]`.
  - `grant` is zero when `in_valid` is zero.
- Arbitration state:
  - `last` (2 bits): lane of the last accepted beat.
  - `cnt` (4 bits): remaining locked beats.
- Lock rule: if `cnt != 0` and `in_valid[last]`, the grant goes to `last`.
- Round-robin rule (when not locked): search lanes `last+1, last+2, last+3, last` (mod 4). The first lane with valid high wins.
- Counter update on each accepted input beat:
  - Same lane as `last` while locked: `cnt <= cnt-1`.
  - New grant under round-robin: `cnt <= BURST-1`.
  - `last` is set to the granted lane.
- Lock release: the lock ends when `cnt` reaches 0, or when `in_valid[last]` is low at a `load` cycle. Round-robin then applies in that same cycle; no idle bubble. A released lock clears `cnt` to 0.
- Output load: on an accepted beat, `out_data <= lane data`, `out_sel <= lane`, `out_valid <= 1`.
- Output hold: if `out_ready` and no lane is valid, `out_valid <= 0` and `out_data`/`out_sel` keep their values.
- While `out_valid & !out_ready`: `out_data`, `out_sel`, `out_valid`, `last` and `cnt` are frozen, and `in_ready` = 0.
- With `BURST=1`: `cnt` is always 0 and behaviour is pure round-robin.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `last=3`, `cnt=0`.
- During and in the cycle of reset assertion, `in_ready=0`. After reset, lane 0 has highest priority.
- Latency: an input beat accepted at edge N appears on `out_data`/`out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle when `out_ready` is held high. No bubble between lanes or bursts.
- Simultaneous events:
  - Output drain and new load in the same cycle are allowed; the register is overwritten.
  - With all four lanes valid, `in_ready` is still one-hot.
- Reset mid-operation: the held output beat is discarded, the lock is cleared and `last` returns to 3. No input is accepted in the reset cycle.
- Input assumption: inputs hold `in_valid`/`in_data` stable until accepted. The block does not rely on this for correctness, and it never accepts from a lane whose `in_valid` is low.

## Test plan
- Reset, then `in_valid=4'b1111` with lanes holding 0xA0..0xA3, `out_ready=1`, `BURST=1`:
  - `out_sel` sequence is 0,1,2,3,0,… and `out_data` is A0,A1,A2,A3.
  - First `out_valid` appears 1 cycle after the first `in_ready`.
- Backpressure: `out_ready=0` for 3 cycles with all lanes valid:
  - `out_valid=1`; `out_data`/`out_sel` stable; `in_ready=0`.
  - On release, the next lane in rotation is granted, with no beat lost or duplicated.
- Sparse requests: only `in_valid[2]` high, `out_ready=1`:
  - Lane 2 is granted every cycle and `out_sel=2` continuously.
  - Raising `in_valid[0]`, with `last=2`, switches the grant to lane 0 on the next cycle.
- Burst lock, `BURST=4`, all lanes valid:
  - `out_sel` = 0,0,0,0,1,1,1,1,2,….
  - Dropping `in_valid[1]` after its 2nd beat gives lane 2 the grant in that same cycle.
- Idle drain: a single beat on lane 3, then all valid low:
  - `out_valid` goes 1 for exactly one cycle, then 0.
  - `out_data`/`out_sel` keep their value (`out_sel=3`).
- Reset mid-burst: assert `rst` for 1 cycle while `out_valid=1` and `cnt=2`:
  - Next cycle `out_valid=0`, `out_sel=0`, `out_data=0`.
  - With all lanes valid, lane 0 is granted first.

Source files
------------

// File: rtl/mux_4_to_1_arbiter.sv
// Registered 4-to-1 mux with round-robin arbitration and optional burst locking.
// Each output beat carries its source lane on out_sel for a downstream demux.
module mux_4_to_1_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  // Handshake: a beat moves on lane i when in_valid[i] & in_ready[i], and on
  // the output when out_valid & out_ready; in_ready never depends on itself.
  localparam logic [3:0] CNT_INIT = 4'(BURST - 1);

  logic [1:0] last;
  logic [3:0] cnt;
  logic       load;
  logic       locked;
  logic       any_valid;
  logic       found;
  logic [1:0] idx;
  logic [1:0] gidx;
  logic [3:0] grant;

  assign load      = !out_valid || out_ready;
  assign locked    = (cnt != 4'd0) && in_valid[last];
  assign any_valid = |in_valid;

  // Lock wins outright; otherwise search last+1 .. last+3, then last itself.
  always_comb begin
    grant = 4'b0000;
    gidx  = last;
    found = 1'b0;
    idx   = last;
    if (locked) begin
      grant[last] = 1'b1;
      gidx        = last;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          gidx       = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign in_ready = (load && !rst) ? grant : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      last      <= 2'd3;
      cnt       <= 4'd0;
    end else if (load) begin
      if (any_valid) begin
        out_data  <= in_data[gidx*WIDTH +: WIDTH];
        out_sel   <= gidx;
        out_valid <= 1'b1;
        last      <= gidx;
        cnt       <= locked ? (cnt - 4'd1) : CNT_INIT;
      end else begin
        // Nothing to take: drain, keep the last beat's data/tag, drop any lock.
        out_valid <= 1'b0;
        cnt       <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mux_4_to_1_arbiter.sv
// Directed bench for mux_4_to_1_arbiter: one instance in pure round-robin,
// one with a 4-beat burst lock, both driven by the same stimulus.
module tb_mux_4_to_1_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]   in_valid = 4'b0000;
  logic         out_ready = 1'b0;

  logic [3:0]   rdy1, rdy4;
  logic [W-1:0] data1, data4;
  logic [1:0]   sel1, sel4;
  logic         vld1, vld4;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  mux_4_to_1_arbiter #(.WIDTH(W), .BURST(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(data1), .out_sel(sel1), .out_valid(vld1),
    .out_ready(out_ready)
  );

  mux_4_to_1_arbiter #(.WIDTH(W), .BURST(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy4), .out_data(data4), .out_sel(sel4), .out_valid(vld4),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int exp_burst[6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset: in_ready stays low while rst is high even with every lane valid.
    tick();
    in_valid = 4'b1111;
    settle();
    chk("rst_rdy1", 32'(rdy1), 32'h0);
    chk("rst_rdy4", 32'(rdy4), 32'h0);
    tick();
    chk("rst_vld", 32'(vld1), 32'h0);
    chk("rst_data", 32'(data1), 32'h0);
    chk("rst_sel", 32'(sel1), 32'h0);
    chk("rst_vld4", 32'(vld4), 32'h0);

    // Round robin, BURST=1: lane 0 first, one-cycle latency.
    rst = 1'b0;
    out_ready = 1'b1;
    settle();
    chk("rr_first_rdy", 32'(rdy1), 32'h1);
    chk("rr_first_vld", 32'(vld1), 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] e;
      chk("rr_rdy", 32'(rdy1), 32'(4'b0001 << (i % 4)));
      exp_q.push_back(8'hA0 + 8'(i % 4));
      tick();
      e = exp_q.pop_front();
      chk("rr_sel", 32'(sel1), 32'(i % 4));
      chk("rr_data", 32'(data1), 32'(e));
      chk("rr_vld", 32'(vld1), 32'h1);
    end

    // Backpressure: held beat from lane 1 stays put, nothing accepted.
    out_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", 32'(rdy1), 32'h0);
      tick();
      chk("bp_vld", 32'(vld1), 32'h1);
      chk("bp_sel", 32'(sel1), 32'h1);
      chk("bp_data", 32'(data1), 32'hA1);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_rel_rdy", 32'(rdy1), 32'h4);
    tick();
    chk("bp_rel_sel", 32'(sel1), 32'h2);
    chk("bp_rel_data", 32'(data1), 32'hA2);

    // Sparse: only lane 2, then lane 0 joins with last=2.
    in_valid = 4'b0100;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("sp_rdy", 32'(rdy1), 32'h4);
      tick();
      chk("sp_sel", 32'(sel1), 32'h2);
      chk("sp_vld", 32'(vld1), 32'h1);
    end
    in_valid = 4'b0101;
    settle();
    chk("sp_sw_rdy", 32'(rdy1), 32'h1);
    tick();
    chk("sp_sw_sel", 32'(sel1), 32'h0);
    chk("sp_sw_data", 32'(data1), 32'hA0);

    // Idle drain: single beat on lane 3, then nothing.
    in_valid = 4'b1000;
    settle();
    chk("dr_rdy", 32'(rdy1), 32'h8);
    tick();
    chk("dr_vld1", 32'(vld1), 32'h1);
    chk("dr_sel1", 32'(sel1), 32'h3);
    in_valid = 4'b0000;
    settle();
    chk("dr_rdy0", 32'(rdy1), 32'h0);
    tick();
    chk("dr_vld0", 32'(vld1), 32'h0);
    chk("dr_sel_keep", 32'(sel1), 32'h3);
    chk("dr_data_keep", 32'(data1), 32'hA3);
    tick();
    chk("dr_vld0b", 32'(vld1), 32'h0);

    // Burst lock, BURST=4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111;
    settle();
    for (int i = 0; i < 6; i++) begin
      chk("bu_rdy", 32'(rdy4), 32'(4'b0001 << exp_burst[i]));
      tick();
      chk("bu_sel", 32'(sel4), 32'(exp_burst[i]));
      chk("bu_data", 32'(data4), 32'(8'hA0 + 8'(exp_burst[i])));
    end
    // Lane 1 drops after its second beat: lane 2 takes the same cycle.
    in_valid = 4'b1101;
    settle();
    chk("bu_drop_rdy", 32'(rdy4), 32'h4);
    tick();
    chk("bu_drop_sel", 32'(sel4), 32'h2);
    chk("bu_drop_data", 32'(data4), 32'hA2);
    chk("bu_lock_rdy", 32'(rdy4), 32'h4);
    tick();
    chk("bu_lock_sel", 32'(sel4), 32'h2);

    // Reset mid-burst (out_valid=1, two locked beats left).
    rst = 1'b1;
    settle();
    chk("mr_rdy", 32'(rdy4), 32'h0);
    tick();
    chk("mr_vld", 32'(vld4), 32'h0);
    chk("mr_sel", 32'(sel4), 32'h0);
    chk("mr_data", 32'(data4), 32'h0);
    rst = 1'b0;
    in_valid = 4'b1111;
    settle();
    chk("mr_first_rdy", 32'(rdy4), 32'h1);
    tick();
    chk("mr_first_sel", 32'(sel4), 32'h0);
    chk("mr_first_data", 32'(data4), 32'hA0);
    chk("mr_first_vld", 32'(vld4), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
